// File: rtl/char_draw_scheduler.sv
// -----------------------------------------------------------------------------
// char_draw_scheduler
//   Round-robin scheduler that shares one glyph-render engine among NUM_REQ
//   text-field requesters. One request is accepted at a time, handed to the
//   renderer, and its completion is awaited before priority rotates.
//
//   Optional feature macro: CHAR_CACHE_EN
//     When defined, a per-requester {valid, coor, char} cache suppresses
//     redraws of an identical glyph. Undefined (default): every accepted
//     request is drawn.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  max cycles spent waiting for draw_done before abort (>=2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_coor     requester i coordinate in bits [12*i+11:12*i]
//   req_char     requester i char code in bits [6*i+5:6*i]
//   req_ready    one-hot accept strobe (only in IDLE)
//   draw_valid   command to renderer valid
//   draw_coor    latched coordinate
//   draw_char    latched char code
//   draw_ready   renderer accepts command
//   draw_done    renderer finished glyph (1-cycle pulse)
//   grant_id     index of requester currently being served
//   busy         scheduler not idle
//   timeout      1-cycle pulse in the final waiting cycle when done never came
// -----------------------------------------------------------------------------
module char_draw_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*12-1:0]      req_coor,
   input  logic [NUM_REQ*6-1:0]       req_char,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       draw_valid,
   output logic [11:0]                draw_coor,
   output logic [5:0]                 draw_char,
   input  logic                       draw_ready,
   input  logic                       draw_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic [11:0]      sel_coor;
   logic [5:0]       sel_char;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept;
   logic             launch;
   logic             hit;

   // Round-robin search starting one past the last winner, wrapping around.
   always_comb begin : arb
      logic [ID_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      sel_coor = '0;
      sel_char = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            sel_coor = req_coor[12*i +: 12];
            sel_char = req_char[6*i +: 6];
         end
      end
   end

`ifdef CHAR_CACHE_EN
   logic [NUM_REQ-1:0] cache_vld;
   logic [11:0]        cache_coor [NUM_REQ];
   logic [5:0]         cache_char [NUM_REQ];

   assign hit = cache_vld[winner] &&
                (cache_coor[winner] == sel_coor) &&
                (cache_char[winner] == sel_char);

   // Only a completed draw refreshes the entry; an aborted draw may not have
   // reached the screen, so the old entry is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            cache_coor[i] <= '0;
            cache_char[i] <= '0;
         end
      end else if (state == WAIT_DONE && draw_done) begin
         cache_vld[grant_id]  <= 1'b1;
         cache_coor[grant_id] <= draw_coor;
         cache_char[grant_id] <= draw_char;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      launch    = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               accept            = 1'b1;
               // A cache hit consumes the request without a redraw.
               if (!hit) begin
                  launch    = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (draw_ready) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Done on the final count wins over the abort.
            if (draw_done) begin
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign draw_valid = (state == ISSUE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= PTR_RST;
         grant_id  <= '0;
         draw_coor <= '0;
         draw_char <= '0;
         wait_cnt  <= '0;
      end else begin
         if (accept) ptr <= winner;
         if (launch) begin
            grant_id  <= winner;
            draw_coor <= sel_coor;
            draw_char <= sel_char;
         end
         // Counter is zero on the first WAIT_DONE cycle.
         if (state == ISSUE)          wait_cnt <= '0;
         else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_char_draw_scheduler.sv
module tb_char_draw_scheduler;

   localparam int N = 4;
   localparam int T = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*12-1:0] req_coor;
   logic [N*6-1:0]  req_char;
   logic [N-1:0]    req_ready;
   logic            draw_valid;
   logic [11:0]     draw_coor;
   logic [5:0]      draw_char;
   logic            draw_ready;
   logic            draw_done;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout;

   logic [11:0] tb_coor [N];
   logic [5:0]  tb_char [N];

   int tests = 0;
   int fails = 0;

   char_draw_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_coor   (req_coor),
      .req_char   (req_char),
      .req_ready  (req_ready),
      .draw_valid (draw_valid),
      .draw_coor  (draw_coor),
      .draw_char  (draw_char),
      .draw_ready (draw_ready),
      .draw_done  (draw_done),
      .grant_id   (grant_id),
      .busy       (busy),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_coor = '0;
      req_char = '0;
      for (int i = 0; i < N; i++) begin
         req_coor[12*i +: 12] = tb_coor[i];
         req_char[6*i +: 6]   = tb_char[i];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req_valid  = '0;
      draw_ready = 1'b0;
      draw_done  = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_phase;   // 0 idle, 1 command offered, 2 awaiting completion
   int          m_cnt;
   int          m_last;
   int          m_gid;
   logic [11:0] m_coor;
   logic [5:0]  m_char;
   bit          mc_vld  [N];
   logic [11:0] mc_coor [N];
   logic [5:0]  mc_char [N];

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic model_init();
      m_phase = 0; m_cnt = 0; m_last = N - 1; m_gid = 0; m_coor = '0; m_char = '0;
      for (int i = 0; i < N; i++) begin
         mc_vld[i] = 1'b0; mc_coor[i] = '0; mc_char[i] = '0;
      end
   endtask

   function automatic bit model_hit(input int w);
`ifdef CHAR_CACHE_EN
      return mc_vld[w] && mc_coor[w] == tb_coor[w] && mc_char[w] == tb_char[w];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_check(input int cyc);
      int          w;
      logic [N-1:0] e_ready;
      logic [63:0]  exp_v;
      logic [63:0]  act_v;
      w       = rr_pick(req_valid, m_last);
      e_ready = (m_phase == 0 && w >= 0) ? N'(1 << w) : '0;
      exp_v = {e_ready, m_phase == 1, m_phase != 0,
               m_phase == 2 && m_cnt == T - 1 && !draw_done,
               2'(m_gid), m_coor, m_char};
      act_v = {req_ready, draw_valid, busy, timeout, grant_id, draw_coor, draw_char};
      tests++;
      if (act_v !== exp_v) begin
         fails++;
         $display("FAIL rand_cycle_%0d: got %0h expected %0h", cyc, act_v, exp_v);
      end
   endtask

   task automatic model_step();
      int w;
      case (m_phase)
         0: begin
            w = rr_pick(req_valid, m_last);
            if (w >= 0) begin
               m_last = w;
               if (!model_hit(w)) begin
                  m_gid = w; m_coor = tb_coor[w]; m_char = tb_char[w]; m_phase = 1;
               end
            end
         end
         1: if (draw_ready) begin m_phase = 2; m_cnt = 0; end
         default: begin
            if (draw_done) begin
               mc_vld[m_gid] = 1'b1; mc_coor[m_gid] = m_coor; mc_char[m_gid] = m_char;
               m_phase = 0;
            end else if (m_cnt == T - 1) m_phase = 0;
            else m_cnt++;
         end
      endcase
   endtask

   // ---------------- table vectors: all requesters, instant completion ----------------
   typedef struct {
      logic [3:0] rv;
      logic       rdy;
      logic       dn;
      logic [3:0] e_ready;
      logic       e_dv;
      logic       e_busy;
      logic [1:0] e_gid;
      logic [11:0] e_coor;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int tcount;
      int tpos;

      tbl[0]  = '{4'hF, 1, 1, 4'b0001, 0, 0, 0, 12'd0};
      tbl[1]  = '{4'hF, 1, 1, 4'b0000, 1, 1, 0, 12'd100};
      tbl[2]  = '{4'hF, 1, 1, 4'b0000, 0, 1, 0, 12'd100};
      tbl[3]  = '{4'hF, 1, 1, 4'b0010, 0, 0, 0, 12'd100};
      tbl[4]  = '{4'hF, 1, 1, 4'b0000, 1, 1, 1, 12'd101};
      tbl[5]  = '{4'hF, 1, 1, 4'b0000, 0, 1, 1, 12'd101};
      tbl[6]  = '{4'hF, 1, 1, 4'b0100, 0, 0, 1, 12'd101};
      tbl[7]  = '{4'hF, 1, 1, 4'b0000, 1, 1, 2, 12'd102};
      tbl[8]  = '{4'hF, 1, 1, 4'b0000, 0, 1, 2, 12'd102};
      tbl[9]  = '{4'hF, 1, 1, 4'b1000, 0, 0, 2, 12'd102};
      tbl[10] = '{4'hF, 1, 1, 4'b0000, 1, 1, 3, 12'd103};
      tbl[11] = '{4'hF, 1, 1, 4'b0000, 0, 1, 3, 12'd103};
      tbl[12] = '{4'hF, 1, 1, 4'b0001, 0, 0, 3, 12'd103};

      for (int i = 0; i < N; i++) begin tb_coor[i] = '0; tb_char[i] = '0; end
      req_valid = '0; draw_ready = 1'b0; draw_done = 1'b0; rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {req_ready, draw_valid, draw_coor, draw_char, grant_id, busy, timeout}, 64'd0);
      rst_n = 1'b1;

      // single request, renderer finishes after 5 waiting cycles
      tb_coor[0] = 12'd1120; tb_char[0] = 6'h0D;
      req_valid = 4'b0001; draw_ready = 1'b1;
      @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk); chk("t1_cmd", {draw_valid, busy, grant_id, draw_coor, draw_char}, {1'b1, 1'b1, 2'd0, 12'd1120, 6'h0D});
      @(posedge clk); #1;
      @(negedge clk); chk("t1_wait", {draw_valid, busy}, 2'b01);
      repeat (4) @(posedge clk);
      #1; draw_done = 1'b1;
      @(negedge clk); chk("t1_no_timeout", timeout, 1'b0);
      @(posedge clk); #1; draw_done = 1'b0;
      @(negedge clk); chk("t1_idle", {busy, draw_valid, draw_coor}, {1'b0, 1'b0, 12'd1120});

      // round-robin order with continuous requests
      do_reset();
      for (int i = 0; i < N; i++) begin tb_coor[i] = 12'(100 + i); tb_char[i] = 6'(i + 1); end
      for (int r = 0; r < 13; r++) begin
         req_valid = tbl[r].rv; draw_ready = tbl[r].rdy; draw_done = tbl[r].dn;
         @(negedge clk);
         chk($sformatf("rr_row_%0d", r),
             {req_ready, draw_valid, busy, grant_id, draw_coor},
             {tbl[r].e_ready, tbl[r].e_dv, tbl[r].e_busy, tbl[r].e_gid, tbl[r].e_coor});
         @(posedge clk); #1;
      end

      // renderer stalls for 10 cycles
      do_reset();
      req_valid = 4'hF; draw_ready = 1'b0;
      @(negedge clk); chk("t3_accept", req_ready, 4'b0001);
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("t3_stall_%0d", c), {req_ready, draw_valid, draw_coor, draw_char},
             {4'b0000, 1'b1, 12'd100, 6'd1});
         @(posedge clk); #1;
      end
      draw_ready = 1'b1; req_valid = '0;
      @(posedge clk); #1;
      @(negedge clk); chk("t3_released", {draw_valid, busy}, 2'b01);

      // timeout with no completion
      do_reset();
      req_valid = 4'b0010; draw_ready = 1'b1;
      @(negedge clk); chk("t4_accept", req_ready, 4'b0010);
      @(posedge clk); #1; req_valid = '0;
      @(posedge clk); #1;
      tcount = 0; tpos = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (timeout) begin tcount++; tpos = n; end
         if (!busy && tcount > 0) break;
         @(posedge clk); #1;
      end
      chk("t4_timeout_count", 64'(tcount), 64'd1);
      chk("t4_timeout_cycle", 64'(tpos), 64'd7);
      chk("t4_busy_fell", busy, 1'b0);
      req_valid = 4'hF; #1;
      chk("t4_next_from_ptr", req_ready, 4'b0100);
      @(posedge clk); #1; req_valid = '0;

      // asynchronous reset while awaiting completion
      do_reset();
      req_valid = 4'b0100; draw_ready = 1'b1;
      @(negedge clk); chk("t5_accept", req_ready, 4'b0100);
      @(posedge clk); #1; req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("t5_reset_now", {req_ready, draw_valid, draw_coor, draw_char, grant_id, busy, timeout}, 64'd0);
      #2; rst_n = 1'b1; req_valid = 4'hF;
      @(negedge clk); chk("t5_req0_first", req_ready, 4'b0001);
      @(posedge clk); #1; req_valid = '0;

      // redraw of an identical glyph
      do_reset();
      tb_coor[1] = 12'd1135; tb_char[1] = 6'h05;
      req_valid = 4'b0010; draw_ready = 1'b1;
      @(negedge clk); chk("t6_first_accept", req_ready, 4'b0010);
      @(posedge clk); #1; req_valid = '0;
      @(posedge clk); #1; draw_done = 1'b1;
      @(posedge clk); #1; draw_done = 1'b0;
      req_valid = 4'b0010;
      @(negedge clk); chk("t6_repeat_accept", req_ready, 4'b0010);
      @(posedge clk); #1; req_valid = '0;
`ifdef CHAR_CACHE_EN
      @(negedge clk); chk("t6_repeat_suppressed", {draw_valid, busy}, 2'b00);
`else
      @(negedge clk); chk("t6_repeat_drawn", {draw_valid, busy}, 2'b11);
`endif
      @(posedge clk); #1; draw_done = 1'b1;
      @(posedge clk); #1; draw_done = 1'b0;
      tb_coor[1] = 12'd1120; tb_char[1] = 6'h0D; req_valid = 4'b0010;
      @(negedge clk); chk("t6_new_accept", req_ready, 4'b0010);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk); chk("t6_new_drawn", {draw_valid, draw_coor, draw_char}, {1'b1, 12'd1120, 6'h0D});

      // randomized traffic against the reference model
      do_reset();
      model_init();
      for (int c = 0; c < 3000; c++) begin
         req_valid  = 4'($urandom_range(0, 15));
         draw_ready = ($urandom_range(0, 2) != 0);
         draw_done  = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < N; i++) begin
            tb_coor[i] = 12'($urandom_range(0, 3));
            tb_char[i] = 6'($urandom_range(0, 1));
         end
         @(negedge clk);
         model_check(c);
         @(posedge clk);
         model_step();
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
